// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmit controller.
// Register offsets are word indices (addr[3:2]) inside the 16-byte window.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_BAUDDIV = 2'd2;

   localparam int ST_BUSY_BIT   = 0;
   localparam int ST_FULL_BIT   = 1;
   localparam int ST_EMPTY_BIT  = 2;
   localparam int ST_OVF_BIT    = 3;
   localparam int ST_CNT_LSB    = 4;
   localparam int ST_PARITY_BIT = 8;

   // A divider of zero would stall the bit counter, so it behaves as one.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// CPU data-memory bus slice seen by the UART: address/store/load strobes in,
// combinational read data and window hit out.
interface mmio_uart_ctrl_if;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] read_data;
   logic        hit;

   modport master (output addr, write_data, mem_write, mem_read, input read_data, hit);
   modport slave  (input addr, write_data, mem_write, mem_read, output read_data, hit);
endinterface

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Synchronous FIFO, head visible combinationally; push ignored when full, pop ignored when empty.
// Fullness and emptiness are the pre-edge values, so a same-cycle push+pop on a full FIFO drops the push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART transmitter: register window decode, TX FIFO and 8N1 bit-timing FSM.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module mmio_uart_ctrl
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic             clk,
   input  logic             reset,
   mmio_uart_ctrl_if.slave  bus,
   output logic             tx
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        hit;
   logic [1:0]  off;
   logic        wr_en, txdata_wr, ovf_set, ovf_clr;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic [CW-1:0] fifo_count;
   logic [31:0] count_ext;
   logic [3:0]  count_sat;
   logic [31:0] status, rdata;
   logic        bit_end, start_frame;
   logic        unused_bits;

   logic [15:0] baud_q, baud_d;
   logic        ovf_q, ovf_d;
   uart_state_e state_q, state_d;
   logic [15:0] div_active_q, div_active_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
`ifdef UART_PARITY_EN
   logic        par_q, par_d;
`endif

   assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign off         = bus.addr[3:2];
   assign bus.hit     = hit;
   assign unused_bits = ^{bus.addr[1:0], bus.write_data[31:16]};

   assign wr_en     = bus.mem_write && hit;
   assign txdata_wr = wr_en && (off == OFF_TXDATA);
   assign fifo_push = txdata_wr && !fifo_full;
   assign ovf_set   = txdata_wr && fifo_full;
   assign ovf_clr   = wr_en && (off == OFF_STATUS) && bus.write_data[ST_OVF_BIT];
   // Set dominates clear so an overflow in the clearing cycle is never lost.
   assign ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
   assign baud_d    = (wr_en && (off == OFF_BAUDDIV)) ? bus.write_data[15:0] : baud_q;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifo_push),
      .push_dat_i (bus.write_data[7:0]),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign count_ext = 32'(fifo_count);
   assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

   always_comb begin
      status                       = '0;
      status[ST_BUSY_BIT]          = (state_q != IDLE);
      status[ST_FULL_BIT]          = fifo_full;
      status[ST_EMPTY_BIT]         = fifo_empty;
      status[ST_OVF_BIT]           = ovf_q;
      status[ST_CNT_LSB +: 4]      = count_sat;
`ifdef UART_PARITY_EN
      status[ST_PARITY_BIT]        = 1'b1;
`endif
   end

   always_comb begin
      rdata = '0;
      if (bus.mem_read && hit) begin
         case (off)
            OFF_STATUS:  rdata = status;
            OFF_BAUDDIV: rdata = {16'h0000, baud_q};
            default:     rdata = '0;
         endcase
      end
   end
   assign bus.read_data = rdata;

   assign bit_end     = (cnt_q == div_active_q - 16'd1);
   // A new frame starts from IDLE, or back-to-back at the last stop-bit cycle.
   assign start_frame = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
   assign fifo_pop    = start_frame;

   always_comb begin
      state_d      = state_q;
      div_active_d = div_active_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
`ifdef UART_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: ;
         START: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            cnt_d = cnt_q + 16'd1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_frame) begin
         shift_d      = fifo_head;
         div_active_d = eff_div(baud_q);
         cnt_d        = '0;
         bit_d        = '0;
         state_d      = START;
`ifdef UART_PARITY_EN
         par_d        = ^fifo_head;
`endif
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         div_active_q <= '0;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         tx_q         <= 1'b1;
         baud_q       <= DEFAULT_DIV;
         ovf_q        <= 1'b0;
`ifdef UART_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         div_active_q <= div_active_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         baud_q       <= baud_d;
         ovf_q        <= ovf_d;
`ifdef UART_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: register decode, frame timing, FIFO overflow,
// mid-frame divider change and reset abort. Honours UART_PARITY_EN for frame length.
module tb_mmio_uart_ctrl;
   localparam logic [31:0] A_TX  = 32'h0000_0400;
   localparam logic [31:0] A_ST  = 32'h0000_0404;
   localparam logic [31:0] A_BD  = 32'h0000_0408;
   localparam logic [31:0] A_RSV = 32'h0000_040C;
`ifdef UART_PARITY_EN
   localparam int          FB  = 11;
   localparam logic [31:0] PAR = 32'h100;
`else
   localparam int          FB  = 10;
   localparam logic [31:0] PAR = 32'h0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic tx;
   int   n_checks = 0;
   int   n_fail = 0;

   mmio_uart_ctrl_if bus ();

   mmio_uart_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr       = a;
      bus.write_data = d;
      bus.mem_write  = 1'b1;
      @(negedge clk);
      bus.mem_write  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.addr     = a;
      bus.mem_read = 1'b1;
      #1;
      d            = bus.read_data;
      bus.mem_read = 1'b0;
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   // Checks tx and busy every cycle over one or two frames; frame 1 uses d1
   // clocks per bit, frame 2 uses d2. Optionally writes BAUDDIV at cycle 5.
   task automatic expect_tx(input string tag, input logic [10:0] f1, input logic [10:0] f2,
                            input int d1, input int d2, input int nfr,
                            input bit mid_en, input logic [15:0] mid_div);
      logic [21:0] seq;
      logic [31:0] st;
      int total, k;
      seq = '1;
      seq[0 +: FB]  = f1[FB-1:0];
      seq[FB +: FB] = f2[FB-1:0];
      total = FB * d1 + ((nfr == 2) ? FB * d2 : 0);
      for (int i = 0; i < total; i++) begin
         bus.mem_write = 1'b0;
         k = (i < FB * d1) ? (i / d1) : (FB + (i - FB * d1) / d2);
         check($sformatf("%s tx cyc%0d", tag, i), {31'b0, tx}, {31'b0, seq[k]});
         rd(A_ST, st);
         check($sformatf("%s busy cyc%0d", tag, i), {31'b0, st[0]}, 32'd1);
         if (mid_en && i == 5) begin
            bus.addr       = A_BD;
            bus.write_data = {16'h0, mid_div};
            bus.mem_write  = 1'b1;
         end
         @(negedge clk);
      end
      bus.mem_write = 1'b0;
      rd(A_ST, st);
      check({tag, " idle status"}, st, 32'h4 | PAR);
      check({tag, " idle tx"}, {31'b0, tx}, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      bit done, any_low;

      reset          = 1'b1;
      bus.addr       = '0;
      bus.write_data = '0;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state and decode
      rd(A_ST, d);  check("reset status", d, 32'h4 | PAR);
      rd(A_BD, d);  check("reset bauddiv", d, 32'd434);
      check("reset tx", {31'b0, tx}, 32'd1);
      rd(A_TX, d);  check("txdata reads 0", d, 32'h0);
      rd(A_RSV, d); check("reserved reads 0", d, 32'h0);
      bus.addr = A_ST; #1;
      check("no mem_read gives 0", bus.read_data, 32'h0);
      check("hit 0x404", {31'b0, bus.hit}, 32'd1);
      bus.addr = 32'h410; #1;
      check("hit 0x410", {31'b0, bus.hit}, 32'd0);
      bus.addr = 32'h3FC; #1;
      check("hit 0x3FC", {31'b0, bus.hit}, 32'd0);
      wr(A_RSV, 32'hFFFF_FFFF);
      rd(A_BD, d);  check("reserved write ignored", d, 32'd434);

      // Single frame, div 4
      wr(A_BD, 32'd4);
      rd(A_BD, d);  check("bauddiv=4", d, 32'd4);
      wr(A_TX, 32'hA5);
      check("tx high at push edge", {31'b0, tx}, 32'd1);
      @(negedge clk);
      expect_tx("a5", frame(8'hA5), '1, 4, 4, 1, 1'b0, 16'd0);

      // Back-to-back frames, div 2, no idle gap
      wr(A_BD, 32'd2);
      wr(A_TX, 32'h55);
      wr(A_TX, 32'h0F);
      expect_tx("b2b", frame(8'h55), frame(8'h0F), 2, 2, 2, 1'b0, 16'd0);

      // Overflow with div 1
      wr(A_BD, 32'd1);
      for (int i = 0; i < 10; i++) wr(A_TX, 32'h10 + i);
      rd(A_ST, d);  check("overflow status", d, 32'h8B | PAR);
      wr(A_ST, 32'h8);
      rd(A_ST, d);  check("overflow cleared", d, 32'h83 | PAR);
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         rd(A_ST, d);
         if (d[0] == 1'b0) done = 1'b1;
         else @(negedge clk);
      end
      check("drain completes", {31'b0, done}, 32'd1);
      rd(A_ST, d);  check("drained status", d, 32'h4 | PAR);

      // Divider change mid-frame applies to the next frame only
      wr(A_BD, 32'd4);
      wr(A_TX, 32'h3C);
      wr(A_TX, 32'hC3);
      expect_tx("middiv", frame(8'h3C), frame(8'hC3), 4, 8, 2, 1'b1, 16'd8);
      rd(A_BD, d);  check("bauddiv=8", d, 32'd8);

      // Reset during DATA with 3 bytes queued
      wr(A_BD, 32'd4);
      for (int i = 0; i < 4; i++) wr(A_TX, 32'h80 + i);
      repeat (6) @(negedge clk);
      rd(A_ST, d);  check("pre-reset status", d, 32'h31 | PAR);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("post-reset tx", {31'b0, tx}, 32'd1);
      rd(A_ST, d);  check("post-reset status", d, 32'h4 | PAR);
      rd(A_BD, d);  check("post-reset bauddiv", d, 32'd434);
      any_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) any_low = 1'b1;
      end
      check("no output after reset", {31'b0, any_low}, 32'd0);
      rd(A_ST, d);  check("final status", d, 32'h4 | PAR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
